// File: rtl/core_pkg.sv
// Shared execute-stage types: instruction and writeback packets plus the
// AGU owner/tag shadow entry used by the AGU issue arbiter.
package core_pkg;

   localparam int PIPE_WIDTH  = 32;
   localparam int TAG_WIDTH   = 6;
   localparam int AGU_NUM_REQ = 4;
   localparam int AGU_OWNER_W = $clog2(AGU_NUM_REQ);

   typedef struct packed {
      logic [TAG_WIDTH-1:0]  dest_tag;
      logic                  is_store;
      logic [PIPE_WIDTH-1:0] base;
      logic [PIPE_WIDTH-1:0] offset;
   } instruction_t;

   typedef struct packed {
      logic                  is_valid;
      logic [TAG_WIDTH-1:0]  dest_tag;
      logic [PIPE_WIDTH-1:0] result;
   } writeback_packet_t;

   // Owner field is sized for AGU_NUM_REQ; keep the arbiter's NUM_REQ in step.
   typedef struct packed {
      logic                   valid;
      logic [AGU_OWNER_W-1:0] owner;
      logic [TAG_WIDTH-1:0]   dest_tag;
   } agu_shadow_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or above ptr_i,
// wrapping explicitly so N need not be a power of two.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         elig_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] grant_idx_o,
   output logic                 any_grant_o
);

   localparam int IW = $clog2(N);

   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      any_grant_o = 1'b0;
      sum         = '0;
      idx         = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_i} + (IW+1)'(k);
         if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
         idx = sum[IW-1:0];
         if (!any_grant_o && elig_i[idx]) begin
            any_grant_o  = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/agu_issue_arbiter.sv
// Shares one fixed-latency AGU among NUM_REQ reservation stations: round-robin
// issue, owner/tag shadow pipe, and routing of AGU results back to their owner.
module agu_issue_arbiter
   import core_pkg::*;
#(
   parameter int NUM_REQ = AGU_NUM_REQ,
   parameter int AGU_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              cache_stall,
   input  logic [NUM_REQ-1:0] req_valid,
   input  instruction_t      req_pkt [NUM_REQ],
   output logic [NUM_REQ-1:0] req_grant,
   output logic              agu_issue_valid,
   output instruction_t      agu_issue_pkt,
   input  writeback_packet_t agu_port,
   output logic [NUM_REQ-1:0] resp_valid,
   output writeback_packet_t resp_pkt,
   output logic              order_err
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int NS = AGU_LAT + 1;

   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0] busy_q, busy_d;
   agu_shadow_t        shadow_q [NS];
   agu_shadow_t        shadow_d [NS];
   logic [NS-1:0]      stale_q, stale_d;
   logic               issue_valid_q;
   instruction_t       issue_pkt_q;
   logic               order_err_q, order_err_d;

   logic [NUM_REQ-1:0] elig, grant;
   logic [IW-1:0]      grant_idx;
   logic               any_grant;
   agu_shadow_t        head;
   logic               head_stale, tag_match, ret_ok, err_set;

   assign elig = req_valid & ~busy_q & {NUM_REQ{~(cache_stall | flush | rst)}};

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .elig_i      (elig),
      .ptr_i       (rr_ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .any_grant_o (any_grant)
   );

   // Stale marks ops killed by a flush: their late AGU results are dropped quietly.
   assign head       = shadow_q[NS-1];
   assign head_stale = stale_q[NS-1];
   assign tag_match  = (agu_port.dest_tag == head.dest_tag);
   assign ret_ok     = ~flush & agu_port.is_valid & head.valid & tag_match;
   assign err_set    = ~flush & ~head_stale &
                       (agu_port.is_valid ? ~(head.valid & tag_match) : head.valid);

   always_comb begin
      resp_valid = '0;
      if (ret_ok) resp_valid[head.owner] = 1'b1;
   end

   always_comb begin
      busy_d      = flush ? '0 : ((busy_q & ~resp_valid) | grant);
      order_err_d = order_err_q | err_set;
      rr_ptr_d    = rr_ptr_q;
      if (any_grant)
         rr_ptr_d = (grant_idx == IW'(NUM_REQ-1)) ? '0 : grant_idx + IW'(1);
      shadow_d[0].valid    = any_grant;
      shadow_d[0].owner    = AGU_OWNER_W'(grant_idx);
      shadow_d[0].dest_tag = req_pkt[grant_idx].dest_tag;
      stale_d[0]           = 1'b0;
      for (int k = 1; k < NS; k++) begin
         shadow_d[k]       = shadow_q[k-1];
         shadow_d[k].valid = shadow_q[k-1].valid & ~flush;
         stale_d[k]        = stale_q[k-1] | (flush & shadow_q[k-1].valid);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q      <= '0;
         busy_q        <= '0;
         stale_q       <= '0;
         issue_valid_q <= 1'b0;
         issue_pkt_q   <= '0;
         order_err_q   <= 1'b0;
         for (int k = 0; k < NS; k++) shadow_q[k] <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         busy_q        <= busy_d;
         shadow_q      <= shadow_d;
         stale_q       <= stale_d;
         issue_valid_q <= any_grant;
         if (any_grant) issue_pkt_q <= req_pkt[grant_idx];
         order_err_q   <= order_err_d;
      end
   end

   assign req_grant       = grant;
   assign agu_issue_valid = issue_valid_q;
   assign agu_issue_pkt   = issue_pkt_q;
   assign resp_pkt        = agu_port;
   assign order_err       = order_err_q;

endmodule

// File: tb/tb_agu_issue_arbiter.sv
// Bench for agu_issue_arbiter: directed scenarios plus random traffic against
// a due-time model of requesters, in-flight ops and a fixed-latency AGU.
module tb_agu_issue_arbiter;
   import core_pkg::*;

   localparam int N   = 4;
   localparam int LAT = 2;

   logic              clk = 1'b0;
   logic              rst, flush, cache_stall;
   logic [N-1:0]      req_valid;
   instruction_t      req_pkt [N];
   logic [N-1:0]      req_grant;
   logic              agu_issue_valid;
   instruction_t      agu_issue_pkt;
   writeback_packet_t agu_port;
   logic [N-1:0]      resp_valid;
   writeback_packet_t resp_pkt;
   logic              order_err;

   agu_issue_arbiter #(.NUM_REQ(N), .AGU_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .flush(flush), .cache_stall(cache_stall),
      .req_valid(req_valid), .req_pkt(req_pkt), .req_grant(req_grant),
      .agu_issue_valid(agu_issue_valid), .agu_issue_pkt(agu_issue_pkt),
      .agu_port(agu_port), .resp_valid(resp_valid), .resp_pkt(resp_pkt),
      .order_err(order_err)
   );

   always #5 clk = ~clk;

   typedef struct {int owner; int tag; int due;} op_t;
   op_t  live_q[$];
   op_t  agu_q[$];
   int   dead_q[$];
   logic [$bits(instruction_t)-1:0] exp_q[$];

   bit           m_busy [N];
   int           m_ptr, cyc;
   bit           m_err, m_iv, cur_flush, e_err_set;
   logic [N-1:0] e_grant, e_resp;
   int           e_gidx;
   int           errors = 0;
   int           checks = 0;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = '0; flush = 1'b0; cache_stall = 1'b0; agu_port = '0;
      @(negedge clk);
      rst = 1'b0;
      live_q.delete(); agu_q.delete(); dead_q.delete(); exp_q.delete();
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_ptr = 0; m_err = 1'b0; m_iv = 1'b0;
      #1;
   endtask

   // Drive one cycle's inputs at the falling edge and predict this cycle's outputs.
   task automatic drive(input logic [N-1:0] rv, input bit st, input bit fl,
                        input int bad_tag, input int set_idx, input int set_tag);
      int i;
      @(negedge clk);
      req_valid = rv; cache_stall = st; flush = fl; cur_flush = fl;
      for (int r = 0; r < N; r++) begin
         req_pkt[r].dest_tag = TAG_WIDTH'($urandom_range(0, 63));
         req_pkt[r].is_store = 1'($urandom_range(0, 1));
         req_pkt[r].base     = $urandom();
         req_pkt[r].offset   = $urandom();
      end
      if (set_idx >= 0) req_pkt[set_idx].dest_tag = TAG_WIDTH'(set_tag);
      agu_port = '0;
      agu_port.result = $urandom();
      if (agu_q.size() > 0 && agu_q[0].due == cyc) begin
         agu_port.is_valid = 1'b1;
         agu_port.dest_tag = TAG_WIDTH'((bad_tag >= 0) ? bad_tag : agu_q[0].tag);
      end
      e_grant = '0; e_gidx = -1;
      if (!fl && !st)
         for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (e_gidx < 0 && rv[i] && !m_busy[i]) begin
               e_gidx = i; e_grant = N'(1) << i;
            end
         end
      e_resp = '0; e_err_set = 1'b0;
      if (!fl) begin
         if (live_q.size() > 0 && live_q[0].due == cyc) begin
            if (agu_port.is_valid && int'(agu_port.dest_tag) == live_q[0].tag)
               e_resp = N'(1) << live_q[0].owner;
            else
               e_err_set = 1'b1;
         end else if (agu_port.is_valid && !(dead_q.size() > 0 && dead_q[0] == cyc))
            e_err_set = 1'b1;
      end
      #1;
   endtask

   // Commit the predicted cycle into the model and cross the rising edge.
   task automatic advance();
      op_t o;
      if (m_iv && exp_q.size() > 0) void'(exp_q.pop_front());
      m_err = m_err | e_err_set;
      for (int r = 0; r < N; r++) if (e_resp[r]) m_busy[r] = 1'b0;
      if (e_gidx >= 0) begin
         m_busy[e_gidx] = 1'b1;
         m_ptr = (e_gidx + 1) % N;
         exp_q.push_back(req_pkt[e_gidx]);
         o = '{e_gidx, int'(req_pkt[e_gidx].dest_tag), cyc + 1 + LAT};
         live_q.push_back(o);
         agu_q.push_back(o);
      end
      m_iv = (e_gidx >= 0);
      if (dead_q.size() > 0 && dead_q[0] == cyc) void'(dead_q.pop_front());
      if (live_q.size() > 0 && live_q[0].due == cyc) void'(live_q.pop_front());
      if (cur_flush) begin
         while (live_q.size() > 0) begin
            o = live_q.pop_front();
            dead_q.push_back(o.due);
         end
         for (int r = 0; r < N; r++) m_busy[r] = 1'b0;
      end
      if (agu_q.size() > 0 && agu_q[0].due == cyc) void'(agu_q.pop_front());
      cyc++;
      @(posedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (req_grant !== '0) begin errors++; $display("FAIL reset_grant got=%b want=0", req_grant); end
      checks++; if (agu_issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got=%b want=0", agu_issue_valid); end
      checks++; if (agu_issue_pkt !== '0) begin errors++; $display("FAIL reset_issue_pkt got=%h want=0", agu_issue_pkt); end
      checks++; if (resp_valid !== '0) begin errors++; $display("FAIL reset_resp got=%b want=0", resp_valid); end
      checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL reset_order_err got=%b want=0", order_err); end
   endtask

   task automatic test_single();
      do_reset();
      drive(4'b0100, 0, 0, -1, 2, 7);
      checks++; if (req_grant !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b want=0100", req_grant); end
      advance();
      drive('0, 0, 0, -1, -1, 0);
      checks++; if (agu_issue_valid !== 1'b1 || agu_issue_pkt.dest_tag !== 6'd7) begin
         errors++; $display("FAIL single_issue got=%b/%0d want=1/7", agu_issue_valid, agu_issue_pkt.dest_tag); end
      advance();
      drive('0, 0, 0, -1, -1, 0);
      checks++; if (resp_valid !== '0) begin errors++; $display("FAIL single_early_resp got=%b want=0", resp_valid); end
      advance();
      drive('0, 0, 0, -1, -1, 0);
      checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL single_resp got=%b want=0100", resp_valid); end
      checks++; if (resp_pkt.dest_tag !== 6'd7) begin errors++; $display("FAIL single_resp_tag got=%0d want=7", resp_pkt.dest_tag); end
      advance();
   endtask

   task automatic test_round_robin();
      int seq[$];
      int want[5] = '{0, 1, 2, 3, 0};
      do_reset();
      for (int c = 0; c < 12; c++) begin
         drive(4'hF, 0, 0, -1, -1, 0);
         checks++; if (req_grant !== e_grant) begin errors++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, req_grant, e_grant); end
         checks++; if (resp_valid !== e_resp) begin errors++; $display("FAIL rr_resp c=%0d got=%b want=%b", c, resp_valid, e_resp); end
         for (int r = 0; r < N; r++) if (req_grant[r]) seq.push_back(r);
         advance();
      end
      checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL rr_order_err got=%b want=0", order_err); end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (k >= seq.size() || seq[k] != want[k]) begin
            errors++; $display("FAIL rr_order k=%0d got=%0d want=%0d", k, (k < seq.size()) ? seq[k] : -1, want[k]);
         end
      end
   endtask

   task automatic test_busy_hold();
      logic [N-1:0] want;
      do_reset();
      for (int k = 0; k < 6; k++) begin
         drive(4'b0010, 0, 0, -1, -1, 0);
         want = (k == 0 || k == 4) ? 4'b0010 : 4'b0000;
         checks++; if (req_grant !== want) begin errors++; $display("FAIL busy_grant k=%0d got=%b want=%b", k, req_grant, want); end
         if (k == 3) begin
            checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL busy_resp got=%b want=0010", resp_valid); end
         end
         advance();
      end
   endtask

   task automatic test_cache_stall();
      do_reset();
      drive(4'b1000, 0, 0, -1, -1, 0);
      checks++; if (req_grant !== 4'b1000) begin errors++; $display("FAIL stall_first got=%b want=1000", req_grant); end
      advance();
      for (int k = 1; k <= 3; k++) begin
         drive(4'b0001, 1, 0, -1, -1, 0);
         checks++; if (req_grant !== '0) begin errors++; $display("FAIL stall_grant k=%0d got=%b want=0", k, req_grant); end
         if (k == 3) begin
            checks++; if (resp_valid !== 4'b1000) begin errors++; $display("FAIL stall_resp got=%b want=1000", resp_valid); end
         end
         advance();
      end
      drive(4'b0001, 0, 0, -1, -1, 0);
      checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL stall_release got=%b want=0001", req_grant); end
      advance();
   endtask

   task automatic test_flush();
      do_reset();
      drive(4'b0011, 0, 0, -1, -1, 0); advance();
      drive(4'b0011, 0, 0, -1, -1, 0); advance();
      drive(4'b0111, 0, 1, -1, -1, 0);
      checks++; if (req_grant !== '0) begin errors++; $display("FAIL flush_grant got=%b want=0", req_grant); end
      advance();
      for (int k = 3; k <= 4; k++) begin
         drive('0, 0, 0, -1, -1, 0);
         checks++; if (resp_valid !== '0) begin errors++; $display("FAIL flush_stale_resp k=%0d got=%b want=0", k, resp_valid); end
         if (k == 3) begin
            checks++; if (agu_issue_valid !== 1'b0) begin errors++; $display("FAIL flush_issue got=%b want=0", agu_issue_valid); end
         end
         advance();
      end
      drive(4'b0011, 0, 0, -1, -1, 0);
      checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL flush_regrant got=%b want=0001", req_grant); end
      checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL flush_order_err got=%b want=0", order_err); end
      advance();
   endtask

   task automatic test_order_err();
      do_reset();
      drive(4'b0001, 0, 0, -1, 0, 5); advance();
      drive('0, 0, 0, -1, -1, 0); advance();
      drive('0, 0, 0, -1, -1, 0); advance();
      drive('0, 0, 0, 9, -1, 0);
      checks++; if (resp_valid !== '0) begin errors++; $display("FAIL err_resp got=%b want=0", resp_valid); end
      advance();
      for (int k = 4; k < 8; k++) begin
         drive('0, 0, 0, -1, -1, 0);
         checks++; if (order_err !== 1'b1) begin errors++; $display("FAIL err_sticky k=%0d got=%b want=1", k, order_err); end
         advance();
      end
      drive(4'b0010, 0, 0, -1, -1, 0);
      checks++; if (req_grant !== 4'b0010) begin errors++; $display("FAIL err_mid_grant got=%b want=0010", req_grant); end
      advance();
      drive(4'b0100, 0, 0, -1, -1, 0); advance();
      do_reset();
      checks++; if (agu_issue_valid !== 1'b0 || agu_issue_pkt !== '0) begin
         errors++; $display("FAIL rst_issue got=%b/%h want=0/0", agu_issue_valid, agu_issue_pkt); end
      checks++; if (resp_valid !== '0 || req_grant !== '0) begin
         errors++; $display("FAIL rst_resp_grant got=%b/%b want=0/0", resp_valid, req_grant); end
      checks++; if (order_err !== 1'b0) begin errors++; $display("FAIL rst_order_err got=%b want=0", order_err); end
      drive(4'b0011, 0, 0, -1, -1, 0);
      checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL rst_regrant got=%b want=0001", req_grant); end
      advance();
   endtask

   task automatic test_random();
      logic [N-1:0] rv;
      bit st, fl;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rv = N'($urandom_range(0, 15));
         st = ($urandom_range(0, 7) == 0);
         fl = ($urandom_range(0, 15) == 0);
         drive(rv, st, fl, -1, -1, 0);
         checks++; if (req_grant !== e_grant) begin errors++; $display("FAIL rand_grant c=%0d got=%b want=%b", c, req_grant, e_grant); end
         checks++; if (resp_valid !== e_resp) begin errors++; $display("FAIL rand_resp c=%0d got=%b want=%b", c, resp_valid, e_resp); end
         checks++; if (resp_pkt !== agu_port) begin errors++; $display("FAIL rand_resp_pkt c=%0d got=%h want=%h", c, resp_pkt, agu_port); end
         checks++; if (agu_issue_valid !== m_iv) begin errors++; $display("FAIL rand_issue_valid c=%0d got=%b want=%b", c, agu_issue_valid, m_iv); end
         if (m_iv && exp_q.size() > 0) begin
            checks++; if (agu_issue_pkt !== exp_q[0]) begin errors++; $display("FAIL rand_issue_pkt c=%0d got=%h want=%h", c, agu_issue_pkt, exp_q[0]); end
         end
         checks++; if (order_err !== m_err) begin errors++; $display("FAIL rand_order_err c=%0d got=%b want=%b", c, order_err, m_err); end
         advance();
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; cache_stall = 1'b0; req_valid = '0; agu_port = '0;
      for (int r = 0; r < N; r++) req_pkt[r] = '0;
      cyc = 0; cur_flush = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_busy_hold();
      test_cache_stall();
      test_flush();
      test_order_err();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
